// File: rtl/gtp_pkg.sv
// gtp_pkg: shared FSM encoding and default credit constants for the GTP credit controller
package gtp_pkg;

   typedef enum logic [2:0] {
      DOWN = 3'b001,
      LOAD = 3'b010,
      RUN  = 3'b100
   } state_t;

   localparam int GTP_NUM_VC       = 3;
   localparam int GTP_CNT_W        = 5;
   localparam int GTP_INIT_CREDITS = 16;
   localparam int GTP_XOFF_THRESH  = 0;

   // Credit-return VC is binary encoded; code 3 carries no VC and is dropped
   localparam int                   GTP_CVC_W    = 2;
   localparam logic [GTP_CVC_W-1:0] GTP_CVC_NONE = 2'd3;

endpackage

// File: rtl/gtp_vc_credit_ctl_if.sv
// gtp_vc_credit_ctl_if: packetizer SOP/xoff and credit-return bundle of the GTP credit controller
interface gtp_vc_credit_ctl_if
   import gtp_pkg::*;
#(
   parameter int NUM_VC = GTP_NUM_VC,
   parameter int CNT_W  = GTP_CNT_W
);

   logic                    i_gtp_out_sop;
   logic [NUM_VC-1:0]       i_gtp_out_vc_enq;
   logic                    i_credit_valid;
   logic [GTP_CVC_W-1:0]    i_credit_vc;
   logic [CNT_W-1:0]        i_credit_cnt;
   logic [NUM_VC-1:0]       o_gtp_out_xoff;
   logic [NUM_VC*CNT_W-1:0] o_credit_level;

   modport master (
      output i_gtp_out_sop, i_gtp_out_vc_enq, i_credit_valid, i_credit_vc, i_credit_cnt,
      input  o_gtp_out_xoff, o_credit_level
   );

   modport slave (
      input  i_gtp_out_sop, i_gtp_out_vc_enq, i_credit_valid, i_credit_vc, i_credit_cnt,
      output o_gtp_out_xoff, o_credit_level
   );

endinterface

// File: rtl/gtp_credit_cnt.sv
// gtp_credit_cnt: one VC's saturating credit counter with sticky ovf/udf flags and registered xoff
module gtp_credit_cnt #(
   parameter int CNT_W        = 5,
   parameter int INIT_CREDITS = 16,
   parameter int XOFF_THRESH  = 0
) (
   input  logic             clk_gtp,
   input  logic             rst_gtp_n,
   input  logic             load,
   input  logic             clear,
   input  logic             run,
   input  logic             off,
   input  logic             consume,
   input  logic [CNT_W-1:0] ret,
   output logic [CNT_W-1:0] cnt,
   output logic             xoff,
   output logic             ovf,
   output logic             udf
);

   localparam logic [CNT_W:0]   INIT_W = (CNT_W+1)'(INIT_CREDITS);
   localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_CREDITS);
   localparam logic [CNT_W-1:0] THR    = CNT_W'(XOFF_THRESH);

   logic [CNT_W:0]   sum, diff;
   logic [CNT_W-1:0] cnt_d;
   logic             under, over, ovf_d, udf_d;

   // Net update one bit wider than the counter; underflow only when nothing is left after the return
   always_comb begin
      sum   = {1'b0, cnt} + {1'b0, ret};
      under = consume && sum == '0;
      diff  = sum - {{CNT_W{1'b0}}, consume};
      over  = !under && diff > INIT_W;
      cnt_d = clear ? '0 : load ? INIT_C : !run ? cnt : under ? '0 : over ? INIT_C : diff[CNT_W-1:0];
      ovf_d = load ? 1'b0 : ovf | (run & !clear & over);
      udf_d = load ? 1'b0 : udf | (run & !clear & under);
   end

   // Counter, flags and xoff all register together so levels and xoff never disagree
   always_ff @(posedge clk_gtp or negedge rst_gtp_n) begin
      if (!rst_gtp_n) begin
         cnt  <= '0;
         xoff <= 1'b1;
         ovf  <= 1'b0;
         udf  <= 1'b0;
      end else begin
         cnt  <= cnt_d;
         xoff <= off | (cnt_d <= THR);
         ovf  <= ovf_d;
         udf  <= udf_d;
      end
   end

endmodule

// File: rtl/gtp_vc_credit_ctl.sv
// gtp_vc_credit_ctl: per-VC credit flow control for the GTP network-in path; GTP_CREDIT_STATS_EN adds stall counters
module gtp_vc_credit_ctl
   import gtp_pkg::*;
#(
   parameter int NUM_VC       = GTP_NUM_VC,
   parameter int CNT_W        = GTP_CNT_W,
   parameter int INIT_CREDITS = GTP_INIT_CREDITS,
   parameter int XOFF_THRESH  = GTP_XOFF_THRESH
) (
   input  logic              clk_gtp,
   input  logic              rst_gtp_n,
   input  logic              i_link_up,
   gtp_vc_credit_ctl_if.slave bus,
   output logic [NUM_VC-1:0] o_err_ovf,
   output logic [NUM_VC-1:0] o_err_udf,
   output logic [2:0]        o_state
`ifdef GTP_CREDIT_STATS_EN
   ,
   input  logic                 i_stats_clr,
   output logic [NUM_VC*32-1:0] o_stall_cnt
`endif
);

   state_t                  state, state_next;
   logic [NUM_VC-1:0]       xoff;
   logic [NUM_VC*CNT_W-1:0] lvl;

   // Link state register
   always_ff @(posedge clk_gtp or negedge rst_gtp_n) begin
      if (!rst_gtp_n) state <= DOWN;
      else            state <= state_next;
   end

   // Down waits for link, Load lasts one cycle, Run holds while the link stays up
   always_comb begin
      state_next = (state == DOWN) ? (i_link_up ? LOAD : DOWN) :
                   (state == LOAD) ? RUN :
                   (state == RUN && i_link_up) ? RUN : DOWN;
   end

   assign o_state            = state;
   assign bus.o_gtp_out_xoff = xoff;
   assign bus.o_credit_level = lvl;

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      logic [CNT_W-1:0] ret;

      assign ret = (bus.i_credit_valid && bus.i_credit_vc != GTP_CVC_NONE &&
                    bus.i_credit_vc == GTP_CVC_W'(v)) ? bus.i_credit_cnt : '0;

      gtp_credit_cnt #(
         .CNT_W       (CNT_W),
         .INIT_CREDITS(INIT_CREDITS),
         .XOFF_THRESH (XOFF_THRESH)
      ) u_cnt (
         .clk_gtp  (clk_gtp),
         .rst_gtp_n(rst_gtp_n),
         .load     (state == LOAD),
         .clear    (state_next == DOWN),
         .run      (state == RUN),
         .off      (state_next != RUN),
         .consume  (bus.i_gtp_out_sop & bus.i_gtp_out_vc_enq[v]),
         .ret      (ret),
         .cnt      (lvl[v*CNT_W +: CNT_W]),
         .xoff     (xoff[v]),
         .ovf      (o_err_ovf[v]),
         .udf      (o_err_udf[v])
      );

`ifdef GTP_CREDIT_STATS_EN
      logic [31:0] stall;

      // Saturating count of Run cycles this VC spends stopped; clear beats increment
      always_ff @(posedge clk_gtp or negedge rst_gtp_n) begin
         if (!rst_gtp_n)                                stall <= '0;
         else if (i_stats_clr)                          stall <= '0;
         else if (state == RUN && xoff[v] && stall != '1) stall <= stall + 32'd1;
      end

      assign o_stall_cnt[v*32 +: 32] = stall;
`endif
   end

endmodule

// File: tb/tb_gtp_vc_credit_ctl.sv
// tb_gtp_vc_credit_ctl: randomized self-checking bench against an integer credit model
module tb_gtp_vc_credit_ctl;
   import gtp_pkg::*;

   localparam int NV = 3, CW = 5, INIT = 16, THR = 0;
   localparam logic [26:0] RST_OBS = {3'b001, 3'b111, 21'b0};

   logic clk_gtp = 0, rst_gtp_n = 0, i_link_up = 0;
   logic [NV-1:0] o_err_ovf, o_err_udf;
   logic [2:0]    o_state;
`ifdef GTP_CREDIT_STATS_EN
   logic             i_stats_clr = 0;
   logic [NV*32-1:0] o_stall_cnt;
`endif

   gtp_vc_credit_ctl_if #(.NUM_VC(NV), .CNT_W(CW)) bus ();

   gtp_vc_credit_ctl #(.NUM_VC(NV), .CNT_W(CW), .INIT_CREDITS(INIT), .XOFF_THRESH(THR)) dut (
      .clk_gtp  (clk_gtp),
      .rst_gtp_n(rst_gtp_n),
      .i_link_up(i_link_up),
      .bus      (bus),
      .o_err_ovf(o_err_ovf),
      .o_err_udf(o_err_udf),
      .o_state  (o_state)
`ifdef GTP_CREDIT_STATS_EN
      ,
      .i_stats_clr(i_stats_clr),
      .o_stall_cnt(o_stall_cnt)
`endif
   );

   always #5 clk_gtp = ~clk_gtp;

   int n_cmp = 0, n_err = 0;

   int          cred[NV];
   bit [NV-1:0] m_ovf, m_udf, m_xoff;
   int          phase;
   longint      m_stall[NV];

   logic [26:0] obs;
   assign obs = {o_state, bus.o_gtp_out_xoff, o_err_ovf, o_err_udf, bus.o_credit_level};

   function automatic logic [26:0] expv();
      logic [14:0] l;
      for (int v = 0; v < NV; v++) l[v*CW +: CW] = CW'(cred[v]);
      return {3'(1 << phase), m_xoff, m_ovf, m_udf, l};
   endfunction

   task automatic model_reset();
      phase = 0; m_ovf = '0; m_udf = '0; m_xoff = '1;
      for (int v = 0; v < NV; v++) begin cred[v] = 0; m_stall[v] = 0; end
   endtask

   task automatic model_step();
`ifdef GTP_CREDIT_STATS_EN
      for (int v = 0; v < NV; v++)
         if (i_stats_clr) m_stall[v] = 0;
         else if (phase == 2 && m_xoff[v] && m_stall[v] < 64'hFFFF_FFFF) m_stall[v]++;
`endif
      if (phase == 0) begin
         if (i_link_up) phase = 1;
      end else if (phase == 1) begin
         phase = 2; m_ovf = '0; m_udf = '0;
         for (int v = 0; v < NV; v++) begin cred[v] = INIT; m_xoff[v] = INIT <= THR; end
      end else if (!i_link_up) begin
         phase = 0; m_xoff = '1;
         for (int v = 0; v < NV; v++) cred[v] = 0;
      end else begin
         for (int v = 0; v < NV; v++) begin
            int c;
            c = cred[v] - int'(bus.i_gtp_out_sop && bus.i_gtp_out_vc_enq[v])
                + ((bus.i_credit_valid && int'(bus.i_credit_vc) == v) ? int'(bus.i_credit_cnt) : 0);
            if (c < 0) begin c = 0; m_udf[v] = 1; end
            else if (c > INIT) begin c = INIT; m_ovf[v] = 1; end
            cred[v] = c;
            m_xoff[v] = c <= THR;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(negedge clk_gtp);
   endtask

   task automatic idle();
      bus.i_gtp_out_sop = 0; bus.i_gtp_out_vc_enq = '0;
      bus.i_credit_valid = 0; bus.i_credit_vc = '0; bus.i_credit_cnt = '0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_gtp);
      n_cmp++;
      if (obs !== RST_OBS) begin n_err++; $display("FAIL reset: got %h want %h", obs, RST_OBS); end
      rst_gtp_n = 1;
      model_reset();
   endtask

   task automatic test_link_up();
      i_link_up = 1;
      tick();
      n_cmp++;
      if (o_state !== 3'b010 || obs !== expv()) begin n_err++; $display("FAIL link_load: got %h want %h", obs, expv()); end
      tick();
      n_cmp++;
      if (obs !== {3'b100, 3'b000, 6'b0, 15'({5'd16, 5'd16, 5'd16})}) begin
         n_err++; $display("FAIL link_run: got %h want run with 16 each", obs);
      end
   endtask

   task automatic test_drain_vc1();
      for (int i = 0; i < 16; i++) begin
         bus.i_gtp_out_sop = 1; bus.i_gtp_out_vc_enq = 3'b010;
         tick();
         n_cmp++;
         if (bus.o_credit_level[9:5] !== 5'(15 - i) || bus.o_credit_level[4:0] !== 5'd16 ||
             bus.o_credit_level[14:10] !== 5'd16 || bus.o_gtp_out_xoff !== ((i == 15) ? 3'b010 : 3'b000) ||
             obs !== expv()) begin
            n_err++; $display("FAIL drain_%0d: got %h want %h", i, obs, expv());
         end
      end
      idle();
   endtask

   task automatic test_net_update();
      bus.i_gtp_out_sop = 1; bus.i_gtp_out_vc_enq = 3'b010;
      bus.i_credit_valid = 1; bus.i_credit_vc = 2'd1; bus.i_credit_cnt = 5'd3;
      tick();
      n_cmp++;
      if (bus.o_credit_level[9:5] !== 5'd2 || o_err_udf !== 3'b000 || bus.o_gtp_out_xoff !== 3'b000 ||
          obs !== expv()) begin
         n_err++; $display("FAIL net_update: got %h want %h", obs, expv());
      end
      idle();
   endtask

   task automatic test_underflow();
      for (int i = 0; i < 3; i++) begin
         bus.i_gtp_out_sop = 1; bus.i_gtp_out_vc_enq = 3'b010;
         tick();
         n_cmp++;
         if (bus.o_credit_level[9:5] !== 5'(i < 2 ? 1 - i : 0) || o_err_udf !== ((i == 2) ? 3'b010 : 3'b000) ||
             obs !== expv()) begin
            n_err++; $display("FAIL underflow_%0d: got %h want %h", i, obs, expv());
         end
      end
      idle();
   endtask

   task automatic test_overflow();
      bus.i_credit_valid = 1; bus.i_credit_vc = 2'd2; bus.i_credit_cnt = 5'd1;
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bus.o_credit_level[14:10] !== 5'd16 || o_err_ovf !== 3'b100 || obs !== expv()) begin
            n_err++; $display("FAIL overflow_%0d: got %h want %h", i, obs, expv());
         end
         tick();
      end
   endtask

   task automatic test_link_drop();
      bus.i_gtp_out_sop = 1; bus.i_gtp_out_vc_enq = 3'b111;
      bus.i_credit_valid = 1; bus.i_credit_vc = 2'd0; bus.i_credit_cnt = 5'd2;
      i_link_up = 0;
      tick();
      n_cmp++;
      if (bus.o_gtp_out_xoff !== 3'b111 || bus.o_credit_level !== '0 || o_state !== 3'b001 || obs !== expv()) begin
         n_err++; $display("FAIL link_drop: got %h want %h", obs, expv());
      end
      for (int i = 0; i < 4; i++) begin
         bus.i_gtp_out_sop = 1; bus.i_gtp_out_vc_enq = 3'(1 << (i % 3));
         bus.i_credit_vc = 2'(i % 3); bus.i_credit_cnt = 5'($urandom_range(0, 31));
         tick();
         n_cmp++;
         if (bus.o_credit_level !== '0 || bus.o_gtp_out_xoff !== 3'b111 || obs !== expv()) begin
            n_err++; $display("FAIL down_hold_%0d: got %h want %h", i, obs, expv());
         end
      end
      idle();
      i_link_up = 1;
      tick(); tick();
      n_cmp++;
      if (obs !== {3'b100, 3'b000, 6'b0, 15'({5'd16, 5'd16, 5'd16})}) begin
         n_err++; $display("FAIL relink: got %h want run with 16 each and no errors", obs);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         i_link_up = $urandom_range(0, 49) != 0;
         bus.i_gtp_out_sop = 1'($urandom_range(0, 1));
         bus.i_gtp_out_vc_enq = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'(1 << $urandom_range(0, 2));
         bus.i_credit_valid = 1'($urandom_range(0, 1));
         bus.i_credit_vc = 2'($urandom_range(0, 3));
         bus.i_credit_cnt = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 2));
         tick();
         n_cmp++;
         if (obs !== expv()) begin n_err++; $display("FAIL random_%0d: got %h want %h", i, obs, expv()); end
      end
      idle();
      i_link_up = 1;
      repeat (3) tick();
   endtask

`ifdef GTP_CREDIT_STATS_EN
   task automatic test_stats();
      for (int i = 0; i < 40 && cred[0] > 0; i++) begin
         bus.i_gtp_out_sop = 1; bus.i_gtp_out_vc_enq = 3'b001;
         tick();
      end
      idle();
      i_stats_clr = 1;
      tick();
      i_stats_clr = 0;
      n_cmp++;
      if (o_stall_cnt[31:0] !== 32'd0) begin n_err++; $display("FAIL stats_clr: got %0d want 0", o_stall_cnt[31:0]); end
      repeat (10) tick();
      n_cmp++;
      if (o_stall_cnt[31:0] !== 32'd10) begin n_err++; $display("FAIL stats_vc0: got %0d want 10", o_stall_cnt[31:0]); end
      for (int v = 0; v < NV; v++) begin
         n_cmp++;
         if (o_stall_cnt[v*32 +: 32] !== 32'(m_stall[v])) begin
            n_err++; $display("FAIL stats_model_%0d: got %0d want %0d", v, o_stall_cnt[v*32 +: 32], m_stall[v]);
         end
      end
   endtask
`endif

   task automatic test_async_reset();
      bus.i_credit_valid = 1; bus.i_credit_vc = 2'd1; bus.i_credit_cnt = 5'd1;
      tick();
      #2 rst_gtp_n = 0;
      #1;
      n_cmp++;
      if (obs !== RST_OBS) begin n_err++; $display("FAIL async_reset: got %h want %h", obs, RST_OBS); end
`ifdef GTP_CREDIT_STATS_EN
      n_cmp++;
      if (o_stall_cnt !== '0) begin n_err++; $display("FAIL async_reset_stats: got %h want 0", o_stall_cnt); end
`endif
      idle();
      @(negedge clk_gtp);
      rst_gtp_n = 1;
      model_reset();
      tick(); tick();
      n_cmp++;
      if (obs !== expv()) begin n_err++; $display("FAIL post_reset_relink: got %h want %h", obs, expv()); end
   endtask

   initial begin
      idle();
      model_reset();
      test_reset();
      test_link_up();
      test_drain_vc1();
      test_net_update();
      test_underflow();
      test_overflow();
      test_link_drop();
      test_random();
`ifdef GTP_CREDIT_STATS_EN
      test_stats();
`endif
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
